// File: rtl/jk_count_ctrl_pkg.sv
// Shared command op codes and sequencer state encodings for the JK counter controller.
package jk_count_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_NOP      = 2'b00,
      OP_LOAD     = 2'b01,
      OP_RUN_UP   = 2'b10,
      OP_RUN_DOWN = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/jk_count_ctrl_if.sv
// Valid/ready command channel into the JK counter controller.
interface jk_count_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;

   modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop, asynchronously cleared to q=0.
module jk_cell (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_count_ctrl.sv
// Command sequencer driving a bank of JK cells as a modulo-MODULUS up/down counter.
module jk_count_ctrl
   import jk_count_ctrl_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic              clk,
   input  logic              reset,
   jk_count_ctrl_if.slave    cmd,
   input  logic              abort,
   output logic [WIDTH-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic              wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   state_e           state_reg, state_next;
   logic [WIDTH-1:0] data_reg, data_next;
   logic             dir_reg, dir_next;
   logic             wrap_reg, wrap_next;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] j_vec, k_vec;
   cmd_op_e          op;

   assign op = cmd_op_e'(cmd.cmd_op);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         data_reg  <= '0;
         dir_reg   <= 1'b0;
         wrap_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         dir_reg   <= dir_next;
         wrap_reg  <= wrap_next;
      end
   end

   // data_reg holds the load value in LOAD and the remaining step count in RUN
   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      dir_next   = dir_reg;
      wrap_next  = 1'b0;
      target     = count;
      case (state_reg)
         S_IDLE: begin
            if (cmd.cmd_valid) begin
               case (op)
                  OP_LOAD: begin
                     data_next  = cmd.cmd_data;
                     state_next = S_LOAD;
                  end
                  OP_RUN_UP, OP_RUN_DOWN: begin
                     data_next  = cmd.cmd_data;
                     dir_next   = (op == OP_RUN_DOWN);
                     state_next = (cmd.cmd_data == '0) ? S_DONE : S_RUN;
                  end
                  default: ;
               endcase
            end
         end
         S_LOAD: begin
            target     = (data_reg > MAX_VAL) ? MAX_VAL : data_reg;
            state_next = S_IDLE;
         end
         S_RUN: begin
            // abort wins over the final step: no move, no done pulse
            if (abort) begin
               state_next = S_IDLE;
            end else begin
               if (!dir_reg) begin
                  wrap_next = (count == MAX_VAL);
                  target    = (count == MAX_VAL) ? '0 : count + WIDTH'(1);
               end else begin
                  wrap_next = (count == '0);
                  target    = (count == '0) ? MAX_VAL : count - WIDTH'(1);
               end
               data_next = data_reg - WIDTH'(1);
               if (data_reg == WIDTH'(1)) begin
                  state_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Only set or clear bits that differ, so the toggle code is never produced
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
      assign j_vec[gi] = target[gi] & ~count[gi];
      assign k_vec[gi] = ~target[gi] & count[gi];

      jk_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (j_vec[gi]),
         .k     (k_vec[gi]),
         .q     (count[gi])
      );
   end

   assign cmd.cmd_ready = (state_reg == S_IDLE);
   assign busy          = (state_reg != S_IDLE);
   assign done          = (state_reg == S_DONE);
   assign wrap          = wrap_reg;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Self-checking bench for jk_count_ctrl: directed and randomized commands against an arithmetic model.
module tb_jk_count_ctrl;

   localparam int W = 4;
   localparam int M = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic         abort;
   logic [W-1:0] count;
   logic         busy, done, wrap;

   int passed = 0;
   int total  = 0;
   int exp_count = 0;

   jk_count_ctrl_if #(.WIDTH(W)) bus ();

   jk_count_ctrl #(.WIDTH(W), .MODULUS(M)) dut (
      .clk   (clk),
      .reset (reset),
      .cmd   (bus),
      .abort (abort),
      .count (count),
      .busy  (busy),
      .done  (done),
      .wrap  (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Monitor: legal excitation, range, and bank movement matching last cycle's J/K
   bit           mon_en  = 0;
   bit           prev_ok = 0;
   logic [W-1:0] prev_q, prev_j, prev_k;

   always @(negedge clk) begin
      #2;
      if (reset) begin
         prev_ok = 0;
      end else if (mon_en) begin
         chk("mon_no_toggle", dut.j_vec & dut.k_vec, 0);
         chk("mon_range", (int'(count) < M), 1);
         if (prev_ok) begin
            chk("mon_j_set", prev_j, count & ~prev_q);
            chk("mon_k_clr", prev_k, ~count & prev_q);
         end
         prev_q  = count;
         prev_j  = dut.j_vec;
         prev_k  = dut.k_vec;
         prev_ok = 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic load_cmd(input int v);
      chk("load_ready_pre", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b01;
      bus.cmd_data  = W'(v);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("load_busy", busy, 1);
      chk("load_ready_low", bus.cmd_ready, 0);
      chk("load_count_hold", count, exp_count);
      @(negedge clk);
      exp_count = (v >= M) ? M - 1 : v;
      chk("load_count", count, exp_count);
      chk("load_idle", busy, 0);
      chk("load_ready", bus.cmd_ready, 1);
      chk("load_no_wrap", wrap, 0);
   endtask

   // abort_at = step index whose edge is suppressed by abort (0 = never)
   task automatic run_cmd(input bit down, input int n, input int abort_at,
                          input bit keep_valid, input int held_load);
      int start;
      start = exp_count;
      chk("run_ready_pre", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = down ? 2'b11 : 2'b10;
      bus.cmd_data  = W'(n);
      @(negedge clk);
      if (keep_valid) begin
         bus.cmd_op   = 2'b01;
         bus.cmd_data = W'(held_load);
      end else begin
         bus.cmd_valid = 1'b0;
      end
      if (n == 0) begin
         chk("run0_done", done, 1);
         chk("run0_count", count, exp_count);
         @(negedge clk);
         chk("run0_done_end", done, 0);
         chk("run0_ready", bus.cmd_ready, 1);
         return;
      end
      chk("run_busy", busy, 1);
      chk("run_ready_low", bus.cmd_ready, 0);
      chk("run_count_hold", count, start);
      for (int i = 1; i <= n; i++) begin
         if (i == abort_at) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_count", count, exp_count);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_ready", bus.cmd_ready, 1);
            return;
         end
         @(negedge clk);
         exp_count = down ? (((start - i) % M) + M) % M : (start + i) % M;
         chk("step_count", count, exp_count);
         chk("step_wrap", wrap, down ? (exp_count == M - 1) : (exp_count == 0));
         chk("step_done", done, (i == n));
      end
      @(negedge clk);
      chk("run_end_done", done, 0);
      chk("run_end_busy", busy, 0);
      chk("run_end_ready", bus.cmd_ready, 1);
      chk("run_end_wrap", wrap, 0);
   endtask

   initial begin
      reset         = 1'b1;
      abort         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_count_held", count, 0);
      reset  = 1'b0;
      mon_en = 1;
      @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_ready", bus.cmd_ready, 1);

      load_cmd(6);
      load_cmd(13);
      load_cmd(8);
      run_cmd(1'b0, 3, 0, 1'b0, 0);
      load_cmd(1);
      run_cmd(1'b1, 2, 0, 1'b0, 0);
      run_cmd(1'b0, 0, 0, 1'b0, 0);

      // abort at count=2 with a LOAD 4 held on the channel throughout the run
      load_cmd(0);
      run_cmd(1'b0, 5, 3, 1'b1, 4);
      chk("held_ready", bus.cmd_ready, 1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("held_busy", busy, 1);
      chk("held_no_done", done, 0);
      @(negedge clk);
      exp_count = 4;
      chk("held_count", count, exp_count);

      // NOP leaves everything alone
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = W'(3);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("nop_count", count, exp_count);
      chk("nop_busy", busy, 0);

      // reset asserted mid-RUN while count=7
      load_cmd(5);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b10;
      bus.cmd_data  = W'(6);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_count", count, 7);
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      @(negedge clk);
      #3 reset = 1'b0;
      exp_count = 0;
      #1;
      chk("post_rst_ready", bus.cmd_ready, 1);
      chk("post_rst_busy", busy, 0);
      repeat (8) begin
         @(negedge clk);
         chk("post_rst_no_done", done, 0);
         chk("post_rst_count", count, 0);
      end

      // randomized command mix
      for (int t = 0; t < 25; t++) begin
         int r;
         int n;
         r = $urandom_range(0, 2);
         n = $urandom_range(0, 15);
         if (r == 0) begin
            load_cmd(n);
         end else begin
            run_cmd(r == 2, n, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0, 1'b0, 0);
         end
      end

      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
